fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage and IF/ID pipeline register for the five-stage MIPS core. It holds the PC, drives the instruction-memory address and latches the fetched word into the D stage. It selects the next PC from the D-stage branch/jump decode, using the equality result from the D-stage comparator and the forwarded rs value. Branches have one architectural delay slot, so taken control transfers never flush.

## Interface
Parameters:
- RESET_PC, 32'h0000_3000, first fetch address and low bound of legal PC range
- IM_WORDS, 4096, instruction-memory depth in words; legal PC range is [RESET_PC, RESET_PC + 4*IM_WORDS)

Ports:
- clk  in  1  core clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- stall  in  1  hazard-unit stall; holds PC and IF/ID
- d_npc_op  in  2  D-stage next-PC select: 0 sequential, 1 conditional branch, 2 j/jal, 3 jr/jalr
- d_jump  in  1  comparator result (rs == rt) for the instruction in D
- d_imm26  in  26  instr[25:0] of the instruction in D; branch offset is [15:0]
- d_rs_val  in  32  forwarded rs value for jr/jalr
- f_pc  out  32  current PC, to instruction memory (combinational read)
- f_instr  in  32  instruction word at f_pc
- d_instr  out  32  IF/ID instruction
- d_pc  out  32  IF/ID PC
- d_pc8  out  32  d_pc + 8, link address for jal/jalr
- pc_fault  out  1  sticky illegal-next-PC flag

## Operation
- seq = f_pc + 4. Instruction in D is at d_pc, delay slot is at f_pc.
- Next PC (npc):
  - op 0: seq
  - op 1 with d_jump=1: d_pc + 4 + (sext(d_imm26[15:0]) << 2)
  - op 1 with d_jump=0: seq
  - op 2: {d_pc[31:28], d_imm26, 2'b00}
  - op 3: d_rs_val
- All arithmetic is 32-bit modulo; wrap is not detected except through the range check.
- Illegal npc: npc[1:0] != 0, npc < RESET_PC, or npc >= RESET_PC + 4*IM_WORDS.
- Normal edge (stall=0, no fault): PC <= npc; d_instr <= f_instr; d_pc <= f_pc; d_pc8 <= f_pc + 8.
- Stall edge: PC and all d_* outputs hold. d_npc_op and d_jump are ignored and re-evaluated next cycle.
- Fault edge (stall=0, npc illegal): pc_fault <= 1, PC holds, IF/ID loads d_instr=0 (nop), d_pc=f_pc, d_pc8=f_pc+8.
- Once pc_fault=1, it stays set until reset. PC stays frozen and IF/ID loads nop every non-stalled edge, regardless of npc.
- Stall takes priority over fault detection; an illegal npc under stall does not set pc_fault.

## Timing
- Reset (reset=0, asynchronous): PC=RESET_PC, d_instr=0, d_pc=0, d_pc8=0, pc_fault=0. The first edge after release latches the instruction at RESET_PC.
- f_pc is registered. npc is combinational from D-stage inputs in the same cycle, so branch resolution in D has zero added latency and no penalty beyond the delay slot.
- Reset asserted mid-stall or mid-fault: all state returns to reset values immediately.
- Simultaneous stall and taken branch: stall wins, and the branch takes effect on the first unstalled edge.

## Structure
- Shared package: npc_op encodings (NPC_SEQ, NPC_BR, NPC_J, NPC_JR), RESET_PC default, NOP word 32'h0.
- One sub-module, npc_calc: purely combinational next-PC mux plus legality check. The PC register, IF/ID register and fault flag stay in fetch_stage.

## Test plan
- Reset release with sequential ops: f_pc steps 0x3000, 0x3004, 0x3008; d_pc lags by one cycle; d_pc8 = d_pc+8.
- beq taken: d_pc=0x3004, offset 0xFFFF, d_jump=1 → the cycle after the delay slot at 0x3008, f_pc=0x3004.
- beq not taken (d_jump=0, op 1) → f_pc continues 0x300C. Then j with imm26=0x0C00 → f_pc=0x3000.
- jr with d_rs_val=0x3010 → f_pc=0x3010. Then jr with d_rs_val=0x3011 → pc_fault=1, f_pc frozen, d_instr=0 on every later edge.
- Stall held 3 cycles during a taken branch → f_pc and d_* unchanged for 3 cycles, then the branch target is loaded on the first unstalled edge.
- reset pulsed low asynchronously mid-cycle while pc_fault=1 → outputs return to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: next-PC select encodings and shared constants for the fetch stage.
package fetch_stage_pkg;
  typedef enum logic [1:0] {
    NPC_SEQ = 2'd0,
    NPC_BR  = 2'd1,
    NPC_J   = 2'd2,
    NPC_JR  = 2'd3
  } npc_op_e;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam logic [31:0] NOP = 32'h0;
endpackage

// File: rtl/fetch_stage_npc_calc.sv
// npc_calc: combinational next-PC mux and legal-range check for the fetch stage.
module npc_calc
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          IM_WORDS = 4096
) (
  input  logic [31:0] i_f_pc,
  input  logic [31:0] i_d_pc,
  input  npc_op_e     i_op,
  input  logic        i_jump,
  input  logic [25:0] i_imm26,
  input  logic [31:0] i_rs_val,
  output logic [31:0] o_npc,
  output logic        o_illegal
);
  // 33-bit bound so a range ending at 2^32 cannot wrap to zero
  localparam logic [32:0] LIMIT = {1'b0, RESET_PC} + 33'(IM_WORDS) * 33'd4;
  logic [31:0] w_seq;
  logic [31:0] w_br;
  assign w_seq = i_f_pc + 32'd4;
  assign w_br  = i_d_pc + 32'd4 + {{14{i_imm26[15]}}, i_imm26[15:0], 2'b00};
  always_comb begin
    o_npc = i_op == NPC_BR ? (i_jump ? w_br : w_seq) :
            i_op == NPC_J  ? {i_d_pc[31:28], i_imm26, 2'b00} :
            i_op == NPC_JR ? i_rs_val : w_seq;
    o_illegal = (|o_npc[1:0]) || (o_npc < RESET_PC) || ({1'b0, o_npc} >= LIMIT);
  end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC register, IF/ID pipeline register and sticky illegal-PC fault
// for the five-stage MIPS core (one branch delay slot, no flush).
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          IM_WORDS = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [1:0]  d_npc_op,
  input  logic        d_jump,
  input  logic [25:0] d_imm26,
  input  logic [31:0] d_rs_val,
  output logic [31:0] f_pc,
  input  logic [31:0] f_instr,
  output logic [31:0] d_instr,
  output logic [31:0] d_pc,
  output logic [31:0] d_pc8,
  output logic        pc_fault
);
  logic [31:0] r_pc, r_instr, r_dpc, r_dpc8;
  logic        r_fault;
  logic [31:0] w_npc;
  logic        w_illegal;
  logic        w_kill;
  npc_calc #(.RESET_PC(RESET_PC), .IM_WORDS(IM_WORDS)) u_npc (
    .i_f_pc    (r_pc),
    .i_d_pc    (r_dpc),
    .i_op      (npc_op_e'(d_npc_op)),
    .i_jump    (d_jump),
    .i_imm26   (d_imm26),
    .i_rs_val  (d_rs_val),
    .o_npc     (w_npc),
    .o_illegal (w_illegal)
  );
  // A fault (new or sticky) freezes the PC and feeds nops into D
  assign w_kill = r_fault || w_illegal;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc    <= RESET_PC;
      r_instr <= NOP;
      r_dpc   <= '0;
      r_dpc8  <= '0;
      r_fault <= 1'b0;
    end else if (!stall) begin
      r_pc    <= w_kill ? r_pc : w_npc;
      r_instr <= w_kill ? NOP : f_instr;
      r_dpc   <= r_pc;
      r_dpc8  <= r_pc + 32'd8;
      r_fault <= w_kill;
    end
  end
  assign f_pc     = r_pc;
  assign d_instr  = r_instr;
  assign d_pc     = r_dpc;
  assign d_pc8    = r_dpc8;
  assign pc_fault = r_fault;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: table-driven vectors with a scoreboard of expected post-edge state,
// plus hand-written asynchronous reset and below-range fault sequences.
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic [1:0]  d_npc_op = 2'd0;
  logic        d_jump = 1'b0;
  logic [25:0] d_imm26 = '0;
  logic [31:0] d_rs_val = '0;
  logic [31:0] f_pc, f_instr, d_instr, d_pc, d_pc8;
  logic        pc_fault;
  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic        stall;
    logic [1:0]  op;
    logic        jump;
    logic [25:0] imm;
    logic [31:0] rs;
    logic [31:0] fpc;
    logic [31:0] dpc;
    logic        nop;
    logic        fault;
  } vec_t;
  typedef struct packed {
    logic [31:0] fpc;
    logic [31:0] dpc;
    logic        nop;
    logic        fault;
  } exp_t;
  vec_t vecs[$];
  exp_t sb[$];

  fetch_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .d_npc_op(d_npc_op), .d_jump(d_jump),
    .d_imm26(d_imm26), .d_rs_val(d_rs_val), .f_pc(f_pc), .f_instr(f_instr),
    .d_instr(d_instr), .d_pc(d_pc), .d_pc8(d_pc8), .pc_fault(pc_fault)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] imem(input logic [31:0] a);
    return 32'hC0DE_0000 | {16'h0, a[15:0]};
  endfunction
  assign f_instr = imem(f_pc);

  function automatic vec_t mk(input logic s, input logic [1:0] op, input logic j,
                              input logic [25:0] imm, input logic [31:0] rs,
                              input logic [31:0] fpc, input logic [31:0] dpc,
                              input logic nop, input logic flt);
    return '{s, op, j, imm, rs, fpc, dpc, nop, flt};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_state(input string tag, input exp_t e);
    check({tag, " f_pc"}, f_pc, e.fpc);
    check({tag, " d_pc"}, d_pc, e.dpc);
    check({tag, " d_pc8"}, d_pc8, e.dpc + 32'd8);
    check({tag, " d_instr"}, d_instr, e.nop ? 32'h0 : imem(e.dpc));
    check({tag, " pc_fault"}, {31'h0, pc_fault}, {31'h0, e.fault});
  endtask

  task automatic check_reset(input string tag);
    check({tag, " f_pc"}, f_pc, 32'h3000);
    check({tag, " d_pc"}, d_pc, 32'h0);
    check({tag, " d_pc8"}, d_pc8, 32'h0);
    check({tag, " d_instr"}, d_instr, 32'h0);
    check({tag, " pc_fault"}, {31'h0, pc_fault}, 32'h0);
  endtask

  task automatic apply(input vec_t v);
    stall = v.stall; d_npc_op = v.op; d_jump = v.jump; d_imm26 = v.imm; d_rs_val = v.rs;
    sb.push_back('{v.fpc, v.dpc, v.nop, v.fault});
    @(posedge clk);
    #1;
  endtask

  initial begin
    // sequential from reset, beq back to itself, not-taken beq, j, jr
    vecs.push_back(mk(0, 0, 0, 26'h0,      32'h0,    32'h3004, 32'h3000, 0, 0));
    vecs.push_back(mk(0, 0, 0, 26'h0,      32'h0,    32'h3008, 32'h3004, 0, 0));
    vecs.push_back(mk(0, 1, 1, 26'hFFFF,   32'h0,    32'h3004, 32'h3008, 0, 0));
    vecs.push_back(mk(0, 0, 0, 26'h0,      32'h0,    32'h3008, 32'h3004, 0, 0));
    vecs.push_back(mk(0, 1, 0, 26'hFFFF,   32'h0,    32'h300C, 32'h3008, 0, 0));
    vecs.push_back(mk(0, 2, 0, 26'h0C00,   32'h0,    32'h3000, 32'h300C, 0, 0));
    vecs.push_back(mk(0, 3, 0, 26'h0,      32'h3010, 32'h3010, 32'h3000, 0, 0));
    vecs.push_back(mk(0, 0, 0, 26'h0,      32'h0,    32'h3014, 32'h3010, 0, 0));
    // taken branch (target 0x3024) held off by a 3-cycle stall
    vecs.push_back(mk(1, 1, 1, 26'h0004,   32'h0,    32'h3014, 32'h3010, 0, 0));
    vecs.push_back(mk(1, 1, 1, 26'h0004,   32'h0,    32'h3014, 32'h3010, 0, 0));
    vecs.push_back(mk(1, 1, 1, 26'h0004,   32'h0,    32'h3014, 32'h3010, 0, 0));
    vecs.push_back(mk(0, 1, 1, 26'h0004,   32'h0,    32'h3024, 32'h3014, 0, 0));
    // top legal word, then an illegal target masked by stall
    vecs.push_back(mk(0, 3, 0, 26'h0,      32'h6FFC, 32'h6FFC, 32'h3024, 0, 0));
    vecs.push_back(mk(1, 3, 0, 26'h0,      32'h7000, 32'h6FFC, 32'h3024, 0, 0));
    vecs.push_back(mk(0, 3, 0, 26'h0,      32'h3000, 32'h3000, 32'h6FFC, 0, 0));
    // misaligned jr faults; fault is sticky and freezes PC
    vecs.push_back(mk(0, 3, 0, 26'h0,      32'h3011, 32'h3000, 32'h3000, 1, 1));
    vecs.push_back(mk(0, 0, 0, 26'h0,      32'h0,    32'h3000, 32'h3000, 1, 1));
    vecs.push_back(mk(0, 3, 0, 26'h0,      32'h3010, 32'h3000, 32'h3000, 1, 1));
    vecs.push_back(mk(1, 0, 0, 26'h0,      32'h0,    32'h3000, 32'h3000, 1, 1));

    #12;
    check_reset("reset");
    @(negedge clk);
    reset = 1'b1;
    foreach (vecs[i]) begin
      apply(vecs[i]);
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL scoreboard empty at vec %0d", i);
      end else check_state($sformatf("vec%0d", i), sb.pop_front());
    end

    // asynchronous reset mid-cycle while faulted, no clock edge before the check
    #2 reset = 1'b0;
    #1 check_reset("async reset");
    @(negedge clk);
    reset = 1'b1;

    // jr below the legal range faults on the first edge
    apply(mk(0, 3, 0, 26'h0, 32'h2FFC, 32'h3000, 32'h3000, 1, 1));
    check_state("below range", sb.pop_front());
    apply(mk(0, 0, 0, 26'h0, 32'h0, 32'h3000, 32'h3000, 1, 1));
    check_state("below range hold", sb.pop_front());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
